// File: rtl/dmem_portb_arbiter_pkg.sv
// Shared types and constants for the dmem port-B arbiter.
package dmem_portb_arbiter_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } grant_t;

endpackage

// File: rtl/dmem_portb_arbiter_arb_wr_fifo.sv
// Synchronous write buffer for keyboard writes; push and pop may share a cycle.
module arb_wr_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   cnt;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == (PTR_W+1)'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/dmem_portb_arbiter.sv
// Cycle-level arbiter sharing dmem port B between buffered keyboard writes and VGA reads.
// Define ARB_STATS_EN to build the saturating VGA stall counter on stat_stalls.
//
// grant    | meaning
// GNT_NONE | port idle, address/data hold last value
// GNT_RD   | VGA read, data returned next cycle
// GNT_WR   | FIFO head written to dmem, VGA stalled
module dmem_portb_arbiter
    import dmem_portb_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          kb_wr_req,
    input  logic [ADDR_W-1:0]             kb_wr_addr,
    input  logic [DATA_W-1:0]             kb_wr_data,
    output logic                          kb_wr_ready,
    output logic                          kb_overflow,
    input  logic                          vga_rd_req,
    input  logic [ADDR_W-1:0]             vga_rd_addr,
    input  logic                          vga_blank,
    output logic                          vga_rd_stall,
    output logic                          vga_rd_valid,
    output logic [DATA_W-1:0]             vga_rd_data,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [DATA_W-1:0]             mem_data,
    output logic                          mem_wren,
    input  logic [DATA_W-1:0]             mem_q,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   stat_stalls
);
    localparam int EW = ADDR_W + DATA_W;
    localparam int SW = $clog2(MAX_WAIT + 1);

    grant_t            grant;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EW-1:0]     head;
    logic [SW-1:0]     starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rd_pending;

    assign kb_wr_ready = !fifo_full;
    assign push        = !reset && kb_wr_req && kb_wr_ready;
    assign pop         = (grant == GNT_WR);

    arb_wr_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({kb_wr_addr, kb_wr_data}),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        grant       = GNT_NONE;
        mem_address = addr_q;
        mem_data    = data_q;
        if (reset) begin
            grant = GNT_NONE;
        end else if (!fifo_empty &&
                     (!vga_rd_req || vga_blank || starve_cnt == SW'(MAX_WAIT))) begin
            grant = GNT_WR;
        end else if (vga_rd_req) begin
            grant = GNT_RD;
        end
        case (grant)
            GNT_WR: begin
                mem_address = head[EW-1:DATA_W];
                mem_data    = head[DATA_W-1:0];
            end
            GNT_RD:  mem_address = vga_rd_addr;
            default: ;
        endcase
        if (reset) begin
            mem_address = '0;
            mem_data    = '0;
        end
    end

    assign mem_wren     = (grant == GNT_WR);
    assign vga_rd_stall = (grant == GNT_WR) && vga_rd_req;
    assign vga_rd_valid = rd_pending;
    assign vga_rd_data  = rd_pending ? mem_q : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt  <= '0;
            rd_pending  <= 1'b0;
            kb_overflow <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            rd_pending <= (grant == GNT_RD);
            addr_q     <= mem_address;
            data_q     <= mem_data;
            if (kb_wr_req && !kb_wr_ready) begin
                kb_overflow <= 1'b1;
            end
            // Starvation guard only runs while a write is waiting and being denied.
            if (fifo_empty || grant == GNT_WR) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(MAX_WAIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (vga_rd_stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stat_stalls = stall_cnt;
`else
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Directed bench for dmem_portb_arbiter with a behavioural one-cycle-latency dmem.
module tb_dmem_portb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        kb_wr_req;
    logic [11:0] kb_wr_addr;
    logic [31:0] kb_wr_data;
    logic        kb_wr_ready;
    logic        kb_overflow;
    logic        vga_rd_req;
    logic [11:0] vga_rd_addr;
    logic        vga_blank;
    logic        vga_rd_stall;
    logic        vga_rd_valid;
    logic [31:0] vga_rd_data;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q = '0;
    logic [2:0]  fifo_count;
    logic [15:0] stat_stalls;

    logic [31:0] dmem [4096];
    int n_cmp = 0;
    int n_err = 0;
    int exp_stalls;

    dmem_portb_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .kb_wr_req    (kb_wr_req),
        .kb_wr_addr   (kb_wr_addr),
        .kb_wr_data   (kb_wr_data),
        .kb_wr_ready  (kb_wr_ready),
        .kb_overflow  (kb_overflow),
        .vga_rd_req   (vga_rd_req),
        .vga_rd_addr  (vga_rd_addr),
        .vga_blank    (vga_blank),
        .vga_rd_stall (vga_rd_stall),
        .vga_rd_valid (vga_rd_valid),
        .vga_rd_data  (vga_rd_data),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .mem_q        (mem_q),
        .fifo_count   (fifo_count),
        .stat_stalls  (stat_stalls)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wren) dmem[mem_address] <= mem_data;
        mem_q <= dmem[mem_address];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [11:0] a, input logic [31:0] d, input logic exp_rdy);
        kb_wr_req  = 1'b1;
        kb_wr_addr = a;
        kb_wr_data = d;
        #1;
        check("push_ready", kb_wr_ready, exp_rdy);
        step();
        kb_wr_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_at;
        int n_stall;
        int n_wr;
        logic [11:0] wr_addr;

        for (int i = 0; i < 4096; i++) dmem[i] = 32'hA000_0000 + i;
`ifdef ARB_STATS_EN
        exp_stalls = 11;
`else
        exp_stalls = 0;
`endif
        reset = 1'b1;
        kb_wr_req = 1'b1; kb_wr_addr = 12'd7; kb_wr_data = 32'h55;
        vga_rd_req = 1'b1; vga_rd_addr = 12'd9; vga_blank = 1'b0;
        step();
        step();
        check("rst_wren", mem_wren, 1'b0);
        check("rst_stall", vga_rd_stall, 1'b0);
        check("rst_addr", mem_address, 12'd0);
        check("rst_data", mem_data, 32'd0);
        kb_wr_req = 1'b0; vga_rd_req = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("rst_count", fifo_count, 3'd0);
        check("rst_ready", kb_wr_ready, 1'b1);
        check("rst_ovf", kb_overflow, 1'b0);
        check("rst_valid", vga_rd_valid, 1'b0);
        check("rst_stats", stat_stalls, 16'd0);

        // 1: plain read
        vga_rd_req = 1'b1; vga_rd_addr = 12'd30;
        #1;
        check("t1_addr", mem_address, 12'd30);
        check("t1_wren", mem_wren, 1'b0);
        check("t1_stall", vga_rd_stall, 1'b0);
        step();
        vga_rd_req = 1'b0;
        #1;
        check("t1_valid", vga_rd_valid, 1'b1);
        check("t1_data", vga_rd_data, 32'hA000_001E);
        check("t1_hold_addr", mem_address, 12'd30);
        step();
        check("t1_valid_drop", vga_rd_valid, 1'b0);
        check("t1_data_zero", vga_rd_data, 32'd0);

        // 2: write waits for blanking
        vga_rd_req = 1'b1; vga_rd_addr = 12'd40;
        push_one(12'd65, 32'h49, 1'b1);
        #1;
        check("t2_count1", fifo_count, 3'd1);
        n_wr = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mem_wren) n_wr++;
            step();
        end
        check("t2_no_active_wr", n_wr, 0);
        vga_blank = 1'b1;
        #1;
        check("t2_wren", mem_wren, 1'b1);
        check("t2_addr", mem_address, 12'd65);
        check("t2_data", mem_data, 32'h49);
        check("t2_stall", vga_rd_stall, 1'b1);
        step();
        vga_blank = 1'b0;
        #1;
        check("t2_count0", fifo_count, 3'd0);
        check("t2_dmem", dmem[65], 32'h49);

        // 3: starvation guard
        push_one(12'd100, 32'hDEAD, 1'b1);
        wr_at = -1; n_stall = 0; wr_addr = '0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (mem_wren && wr_at < 0) begin
                wr_at = i;
                wr_addr = mem_address;
            end
            if (vga_rd_stall) n_stall++;
            step();
        end
        check("t3_force_cycle", wr_at, 64);
        check("t3_force_addr", wr_addr, 12'd100);
        check("t3_stall_once", n_stall, 1);
        check("t3_dmem", dmem[100], 32'hDEAD);

        // 4: overflow and ordered drain
        for (int k = 0; k < 5; k++) push_one(12'(200 + k), 32'(256 + k), k < 4);
        #1;
        check("t4_count", fifo_count, 3'd4);
        check("t4_ready", kb_wr_ready, 1'b0);
        check("t4_ovf", kb_overflow, 1'b1);
        vga_blank = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t4_drain_wren", mem_wren, 1'b1);
            check("t4_drain_addr", mem_address, 12'(200 + k));
            check("t4_drain_data", mem_data, 32'(256 + k));
            step();
        end
        #1;
        check("t4_empty", fifo_count, 3'd0);
        check("t4_rd_after", mem_wren, 1'b0);
        check("t4_dropped", dmem[204], 32'hA000_00CC);
        vga_blank = 1'b0;

        // 5: simultaneous push/pop at full and at half
        for (int k = 0; k < 4; k++) push_one(12'(300 + k), 32'(768 + k), 1'b1);
        vga_blank = 1'b1;
        kb_wr_req = 1'b1; kb_wr_addr = 12'd304; kb_wr_data = 32'h330;
        #1;
        check("t5_full_ready", kb_wr_ready, 1'b0);
        check("t5_pop_addr", mem_address, 12'd300);
        step();
        kb_wr_req = 1'b0; vga_blank = 1'b0;
        #1;
        check("t5_count3", fifo_count, 3'd3);
        vga_blank = 1'b1;
        #1;
        check("t5_pop2_addr", mem_address, 12'd301);
        step();
        vga_blank = 1'b0;
        #1;
        check("t5_count2", fifo_count, 3'd2);
        vga_blank = 1'b1;
        push_one(12'd305, 32'h331, 1'b1);
        vga_blank = 1'b0;
        #1;
        check("t5_count2_pp", fifo_count, 3'd2);
        vga_blank = 1'b1;
        #1;
        check("t5_order_a", mem_address, 12'd303);
        step();
        #1;
        check("t5_order_b", mem_address, 12'd305);
        check("t5_order_b_data", mem_data, 32'h331);
        step();
        vga_blank = 1'b0;
        #1;
        check("t5_empty", fifo_count, 3'd0);
        check("t5_dropped", dmem[304], 32'hA000_0130);
        check("stats_total", stat_stalls, 16'(exp_stalls));

        // 6: reset mid-operation
        for (int k = 0; k < 3; k++) push_one(12'(400 + k), 32'(1024 + k), 1'b1);
        #1;
        check("t6_count3", fifo_count, 3'd3);
        check("t6_valid_pre", vga_rd_valid, 1'b1);
        reset = 1'b1; kb_wr_req = 1'b1; kb_wr_addr = 12'd410;
        #1;
        check("t6_rst_wren", mem_wren, 1'b0);
        check("t6_rst_stall", vga_rd_stall, 1'b0);
        check("t6_rst_addr", mem_address, 12'd0);
        step();
        reset = 1'b0; kb_wr_req = 1'b0; vga_rd_req = 1'b0;
        #1;
        check("t6_count0", fifo_count, 3'd0);
        check("t6_valid0", vga_rd_valid, 1'b0);
        check("t6_wren0", mem_wren, 1'b0);
        check("t6_stats0", stat_stalls, 16'd0);
        check("t6_ovf0", kb_overflow, 1'b0);
        step();
        check("t6_no_drain", dmem[400], 32'hA000_0190);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
